// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcode values and FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XNOR = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ROT  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_flags.sv
// Combinational zero/sign/positive flags derived from an ALU result.
module alu_flags #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] r,
    output logic             zf,
    output logic             sf,
    output logic             gt_zero
);

    assign zf      = (r == '0);
    assign sf      = r[WIDTH-1];
    assign gt_zero = !sf && !zf;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, rotates stepped one bit per
// clock, valid/ready handshake on both sides with registered result and flags.
module mc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             ZF,
    output logic             SF,
    output logic             CF,
    output logic             GT_ZERO
);

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             rot_left, rot_left_next;
    logic [WIDTH-1:0] r_next;
    logic             cf_next;
    logic             r_load;
    logic             zf_next, sf_next, gt_next;
    logic             accept;
    op_e              op_in;
    logic [CNT_W-1:0] k;
    logic [WIDTH:0]   sum, diff;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign op_in     = op_e'(OP);
    assign k         = CNT_W'(B % WIDTH);
    // The extra top bit of the subtraction is the unsigned borrow (A < B).
    assign sum       = {1'b0, A} + {1'b0, B};
    assign diff      = {1'b0, A} - {1'b0, B};

    alu_flags #(.WIDTH(WIDTH)) u_flags (
        .r       (r_next),
        .zf      (zf_next),
        .sf      (sf_next),
        .gt_zero (gt_next)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        rot_left_next = rot_left;
        r_next        = R;
        cf_next       = CF;
        r_load        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (state == DONE && out_ready) state_next = IDLE;
                if (accept) begin
                    r_load     = 1'b1;
                    state_next = DONE;
                    cf_next    = 1'b0;
                    case (op_in)
                        OP_AND:  r_next = A & B;
                        OP_OR:   r_next = A | B;
                        OP_XNOR: r_next = ~(A ^ B);
                        OP_ADD:  {cf_next, r_next} = sum;
                        OP_SUB:  {cf_next, r_next} = diff;
                        OP_ROR, OP_ROL: begin
                            r_next        = A;
                            rot_left_next = (op_in == OP_ROL);
                            if (k != '0) begin
                                cnt_next   = k;
                                state_next = ROT;
                            end
                        end
                        default: r_next = '0;
                    endcase
                end
            end
            ROT: begin
                r_load   = 1'b1;
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_next = DONE;
                if (rot_left) begin
                    r_next  = {R[WIDTH-2:0], R[WIDTH-1]};
                    cf_next = R[WIDTH-1];
                end else begin
                    r_next  = {R[0], R[WIDTH-1:1]};
                    cf_next = R[0];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rot_left <= 1'b0;
            R        <= '0;
            CF       <= 1'b0;
            ZF       <= 1'b0;
            SF       <= 1'b0;
            GT_ZERO  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            rot_left <= rot_left_next;
            if (r_load) begin
                R       <= r_next;
                CF      <= cf_next;
                ZF      <= zf_next;
                SF      <= sf_next;
                GT_ZERO <= gt_next;
            end
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu (WIDTH=6): directed vectors, handshake and reset
// corner sequences, and random operations against an arithmetic reference model.
module tb_mc_alu;

    localparam int W = 6;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, r;
    logic [2:0]   op;
    logic         zf, sf, cf, gt;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [3:0]   flg;  // {ZF, SF, CF, GT_ZERO}
        int           lat;
    } vec_t;

    vec_t vecs[13];

    mc_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .OP        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (r),
        .ZF        (zf),
        .SF        (sf),
        .CF        (cf),
        .GT_ZERO   (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_of(input logic [W-1:0] res, input logic c);
        return {res == 0, res[W-1], c, $signed(res) > 0};
    endfunction

    // Reference: plain arithmetic on integers, rotates as shift-or, latency from k.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] res, output logic c, output int lat);
        int k, xv, s;
        k   = int'(y) % W;
        xv  = int'(x);
        c   = 1'b0;
        lat = 1;
        res = '0;
        case (o)
            3'd0: res = x & y;
            3'd1: res = x | y;
            3'd2: res = ~(x ^ y);
            3'd3: begin s = int'(x) + int'(y); res = W'(s); c = (s >= (1 << W)); end
            3'd4: begin s = int'(x) - int'(y); res = W'(s); c = (s < 0); end
            3'd5: begin
                res = W'((xv >> k) | (xv << (W - k)));
                if (k != 0) begin c = ((xv >> (k - 1)) & 1) != 0; lat = k + 1; end
            end
            3'd6: begin
                res = W'((xv << k) | (xv >> (W - k)));
                if (k != 0) begin c = ((xv >> (W - k)) & 1) != 0; lat = k + 1; end
            end
            default: res = '0;
        endcase
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge, idle again.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] er, input logic [3:0] ef, input int el,
                          input int hold, input string tag);
        int lat;
        check({tag, "_idle_ready"}, 32'(in_ready), 1);
        check({tag, "_idle_valid"}, 32'(out_valid), 0);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            check({tag, "_busy_ready"}, 32'(in_ready), 0);
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, lat, el);
        check({tag, "_r"}, 32'(r), 32'(er));
        check({tag, "_flags"}, 32'({zf, sf, cf, gt}), 32'(ef));
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold_r"}, 32'(r), 32'(er));
            check({tag, "_hold_flags"}, 32'({zf, sf, cf, gt}), 32'(ef));
            check({tag, "_hold_valid"}, 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] mr;
        logic         mc;
        int           ml, hold;
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{3'b000, 6'b110011, 6'b101010, 6'b100010, 4'b0100, 1};
        vecs[1]  = '{3'b101, 6'b110011, 6'b000001, 6'b111001, 4'b0110, 2};
        vecs[2]  = '{3'b101, 6'b101010, 6'b000010, 6'b101010, 4'b0110, 3};
        vecs[3]  = '{3'b011, 6'b111111, 6'b000001, 6'b000000, 4'b1010, 1};
        vecs[4]  = '{3'b100, 6'b000000, 6'b000001, 6'b111111, 4'b0110, 1};
        vecs[5]  = '{3'b110, 6'b000001, 6'b000110, 6'b000001, 4'b0001, 1};
        vecs[6]  = '{3'b110, 6'b100000, 6'b000001, 6'b000001, 4'b0011, 2};
        vecs[7]  = '{3'b001, 6'b000101, 6'b010000, 6'b010101, 4'b0001, 1};
        vecs[8]  = '{3'b010, 6'b101010, 6'b010101, 6'b000000, 4'b1000, 1};
        vecs[9]  = '{3'b111, 6'b111111, 6'b111111, 6'b000000, 4'b1000, 1};
        vecs[10] = '{3'b101, 6'b000001, 6'b000101, 6'b000010, 4'b0001, 6};
        vecs[11] = '{3'b110, 6'b000011, 6'b111111, 6'b011000, 4'b0001, 4};
        vecs[12] = '{3'b100, 6'b000101, 6'b000011, 6'b000010, 4'b0001, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
        repeat (2) @(negedge clk);
        check("reset_r", 32'(r), 0);
        check("reset_flags", 32'({zf, sf, cf, gt}), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].flg, vecs[i].lat, 0,
                   $sformatf("vec%0d", i));

        // Stall the consumer three cycles, then release it with a new op waiting.
        op = 3'b011; a = 6'b000011; b = 6'b000100; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = 6'b111111; b = 6'b111111; op = 3'b111;
        check("stall_valid", 32'(out_valid), 1);
        check("stall_r", 32'(r), 32'(6'b000111));
        check("stall_flags", 32'({zf, sf, cf, gt}), 32'(4'b0001));
        repeat (3) begin
            @(negedge clk);
            check("stall_hold_valid", 32'(out_valid), 1);
            check("stall_hold_r", 32'(r), 32'(6'b000111));
            check("stall_hold_flags", 32'({zf, sf, cf, gt}), 32'(4'b0001));
            check("stall_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1; in_valid = 1'b1; op = 3'b000; a = 6'b111100; b = 6'b001111;
        #1;
        check("b2b_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_valid", 32'(out_valid), 1);
        check("b2b_r", 32'(r), 32'(6'b001100));
        check("b2b_flags", 32'({zf, sf, cf, gt}), 32'(4'b0001));
        @(negedge clk);
        check("b2b_drained", 32'(out_valid), 0);

        // Abort a rotate partway through with an asynchronous reset pulse.
        op = 3'b101; a = 6'b110011; b = 6'b000101; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy_valid", 32'(out_valid), 0);
        check("abort_mid_r", 32'(r), 32'(6'b111001));
        #2 rst_n = 1'b0;
        #1;
        check("abort_r", 32'(r), 0);
        check("abort_flags", 32'({zf, sf, cf, gt}), 0);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 0);
        end

        for (int n = 0; n < 200; n++) begin
            ro   = 3'($urandom_range(0, 7));
            ra   = W'($urandom);
            rb   = W'($urandom);
            hold = $urandom_range(0, 2);
            model(ro, ra, rb, mr, mc, ml);
            run_op(ro, ra, rb, mr, flags_of(mr, mc), ml, hold, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter WIDTH, default 6, operand and result width in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default $clog2(WIDTH), width of the rotate step counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B; for rotates, the rotate amount.
REQ-009 OP  input  3  opcode: 000 AND, 001 OR, 010 XNOR, 011 ADD, 100 SUB, 101 ROR, 110 ROL, 111 reserved.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 R  output  WIDTH  registered result.
REQ-013 ZF, SF, CF, GT_ZERO  output  1 each  registered flags.

Function
REQ-014 The FSM SHALL have three states: IDLE, ROT, DONE.
REQ-015 Handshake: transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 in_ready = (state==IDLE) || (state==DONE && out_ready); out_valid = (state==DONE).
REQ-017 On accept, A, B and OP SHALL be captured; later changes on A/B/OP SHALL have no effect until the next accept.
REQ-018 AND/OR/XNOR/ADD/SUB/reserved: result registered on the accept edge; IDLE/DONE->DONE; latency 1 cycle.
REQ-019 ADD: R = (A+B) mod 2^WIDTH, CF = carry out; SUB: R = (A-B) mod 2^WIDTH, CF = borrow (A<B unsigned).
REQ-020 Logic ops and reserved: CF=0; reserved R = 0.
REQ-021 ROR/ROL: rotate amount k = B mod WIDTH; k==0 -> DONE on accept edge, R=A, CF=0, latency 1.
REQ-022 k>=1: accept edge loads shifter with A and counter with k, enters ROT; each ROT edge rotates one bit and decrements; leaves ROT for DONE on the edge where the counter is 1; latency k+1 cycles.
REQ-023 ROR CF = last bit shifted out of bit 0; ROL CF = last bit shifted out of bit WIDTH-1.
REQ-024 Flags computed from final R: ZF = (R==0); SF = R[WIDTH-1]; GT_ZERO = !SF && !ZF (signed > 0).
REQ-025 R and all flags SHALL hold stable while out_valid && !out_ready.
REQ-026 DONE with out_ready and no in_valid -> IDLE; DONE with out_ready and in_valid -> accept back-to-back, no bubble.
REQ-027 in_valid during ROT SHALL be ignored (in_ready=0); no transaction is lost or duplicated.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, R=0, ZF=0, SF=0, CF=0, GT_ZERO=0, out_valid=0.
REQ-029 Reset asserted during ROT or DONE SHALL abort the operation; no out_valid for it after release.
REQ-030 First accept possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode enum (3-bit) and the FSM state enum.
REQ-032 Sub-module alu_flags (combinational, WIDTH-parametrised) SHALL derive ZF/SF/GT_ZERO from a result; CF stays in mc_alu.

Verification (WIDTH=6)
REQ-033 AND A=110011 B=101010 -> R=100010, ZF0 SF1 CF0 GT_ZERO0, out_valid 1 cycle after accept.
REQ-034 ROR A=110011 B=000001 -> R=111001, CF1, SF1, latency 2; ROR A=101010 B=000010 -> R=101010, CF1, latency 3.
REQ-035 ADD 111111+000001 -> R=000000 ZF1 CF1 GT_ZERO0; SUB 000000-000001 -> R=111111 CF1 SF1 ZF0.
REQ-036 ROL A=000001 B=000110 (k=0) -> R=000001, CF0, GT_ZERO1, latency 1; ROL A=100000 B=000001 -> R=000001, CF1.
REQ-037 Hold out_ready=0 three cycles -> R/flags stable, in_ready 0; then out_ready=1 with in_valid=1 -> new op accepted same edge.
REQ-038 Pulse rst_n low mid-ROR (A=110011 B=000101) -> outputs 0 asynchronously, IDLE, no out_valid afterwards.
